fibl_responder: RTL and testbench
=================================

# fibl_responder

Hand-written iterative Fibonacci engine that implements the callee end of the `start`/`busy` call protocol used by the compiled `tests_fibl` test modules. It accepts an argument on a one-cycle `start` pulse, holds `busy` high while iterating, and presents a registered result with a completion strobe. It sits behind a top-level board wrapper as a drop-in, cycle-accurate reference responder. Benches run it side by side with compiled modules to cross-check results and handshake behaviour.

## Interface
- `intN`, default 16 — data width in bits, shared with `primitives.v`; `intT` is `[intN-1:0]`.
- `clk` input 1 — sole clock; all state changes on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `start` input 1 — call request; sampled only when `busy`=0.
- `in` input intN — argument n, unsigned; sampled with `start`.
- `out` output intN — result fib(n) mod 2^intN; holds until the next completion.
- `busy` output 1 — high while a call is in progress.
- `done` output 1 — one-cycle strobe; `out`/`ovf` valid from this cycle.
- `ovf` output 1 — high iff true fib(n) ≥ 2^intN for the last completed call.

## Operation
- States:
  - IDLE: `busy`=0.
  - ITER: `busy`=1.
- IDLE, `start`=1 → ITER.
  - Load a=0, b=1, cnt=`in`; clear carry tags.
- IDLE, `start`=0 → stay in IDLE.
- ITER, cnt≠0:
  - a←b, b←a+b (mod 2^intN), cnt←cnt−1.
  - Carry tags: tag_a←tag_b; tag_b←carry(a+b) | tag_a | tag_b.
- ITER, cnt=0 → IDLE.
  - `out`←a, `ovf`←tag_a, `done`=1 for one cycle.
- Fibonacci definition: fib(0)=0, fib(1)=1.
- Overflow semantics:
  - b runs one term ahead, so overflow of b alone never sets `ovf`; only the tag carried into a counts.
  - For intN=16: fib(24)=46368 gives `ovf`=0; fib(25) gives `out`=9489 with `ovf`=1.
- `start` while `busy`=1 is ignored and never queued.
- cnt is intN bits wide; any n up to 2^intN−1 is accepted, and latency scales with n.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, `ovf`=0, state IDLE, a=b=cnt=0.
- Call cycle numbering: `start` sampled at edge T0.
  - `busy`=1 from T0+1 through T0+n+1.
  - At T0+n+2: `busy`=0, `done`=1, `out`=fib(n).
- Busy duration is n+1 cycles; n=0 gives 1 busy cycle and `out`=0 at T0+2.
- The earliest next `start` is sampled at the `done` cycle, since `busy`=0 there. Back-to-back calls therefore have zero idle cycles.
- `done` is never high while `busy`=1.
- `out` and `ovf` change only on the `done` cycle, or on reset.
- `rst` asserted mid-call:
  - Next edge returns all outputs to their reset values.
  - The call is abandoned with no `done`.
  - `start` in the same cycle as `rst` is dropped.

## Configuration
- `FIBL_MEMO_EN` defined:
  - A one-entry cache of the last completed (n, `out`, `ovf`) is kept, with a valid bit.
  - A `start` in IDLE whose `in` matches the cached n while the cache is valid does not enter ITER. `busy` stays 0.
  - At T0+1: `done`=1, and `out`/`ovf` keep their cached values.
  - Reset clears the valid bit.
  - An abandoned call does not update the cache.
- `FIBL_MEMO_EN` undefined:
  - No cache logic.
  - Every call takes n+1 busy cycles, including repeats.

## Test plan
- Reset, then `start` with n=0: `busy` high one cycle, then `done`=1, `out`=0, `ovf`=0 at T0+2.
- n=10: `busy` high 11 cycles, `out`=55, `done` single cycle. Then n=24: `out`=46368, `ovf`=0.
- n=25: `out`=9489, `ovf`=1. Then n=3: `out`=2, and `ovf` returns to 0.
- `start` pulses during `busy` of an n=20 call are ignored: exactly one `done` and `out`=6765. Then a `start` on the `done` cycle with n=5 completes with `out`=5.
- `rst` asserted mid-call during n=20, at cycle T0+8: next cycle `busy`=0, `out`=0, `done` never pulses.
- `FIBL_MEMO_EN` defined:
  - n=12 (`out`=144), then n=12 again: `busy` stays 0 and `done` is at T0+1 with `out`=144.
  - After `rst`, n=12 takes the full 13 busy cycles.
  - Without the macro, the repeated call takes 13 busy cycles.

Source files
------------

// File: rtl/fibl_responder_if.sv
// Call/return bundle between a caller and the fibl_responder.
//   start : one-cycle call request (caller -> responder)
//   in    : argument n, sampled with start
//   out   : fib(n) mod 2^intN, held until the next completion
//   busy  : call in progress
//   done  : one-cycle completion strobe
//   ovf   : true fib(n) did not fit in intN bits
interface fibl_responder_if #(
  parameter int unsigned intN = 16
);
  logic            start;
  logic [intN-1:0] in;
  logic [intN-1:0] out;
  logic            busy;
  logic            done;
  logic            ovf;

  modport master (output start, in, input out, busy, done, ovf);
  modport slave  (input start, in, output out, busy, done, ovf);
endinterface

// File: rtl/fibl_responder.sv
// Iterative Fibonacci engine, callee side of the start/busy call protocol.
// Accepts n on a start pulse while idle, iterates n+1 busy cycles, then
// presents fib(n) mod 2^intN with an overflow flag and a one-cycle done.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fibl_responder_if.slave (start, in, out, busy, done, ovf)
// Optional feature: define FIBL_MEMO_EN to keep a one-entry cache of the
// last completed call; a repeated n then completes in one cycle without busy.
module fibl_responder #(
  parameter int unsigned intN = 16
) (
  input  logic              clk,
  input  logic              rst,
  fibl_responder_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [intN-1:0] a_q, a_d;
  logic [intN-1:0] b_q, b_d;
  logic [intN-1:0] cnt_q, cnt_d;
  logic            tag_a_q, tag_a_d;
  logic            tag_b_q, tag_b_d;
  logic [intN-1:0] out_q, out_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [intN:0]   sum_c;
  logic            memo_hit_c;

`ifdef FIBL_MEMO_EN
  logic            memo_valid_q, memo_valid_d;
  logic [intN-1:0] memo_n_q, memo_n_d;
  logic [intN-1:0] n_q, n_d;

  // Cached result is reusable only for the exact same argument
  assign memo_hit_c = memo_valid_q && (bus.in == memo_n_q);
`else
  assign memo_hit_c = 1'b0;
`endif

  // Widened add so the carry out of the b term can be tagged
  assign sum_c = {1'b0, a_q} + {1'b0, b_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start && !memo_hit_c) state_d = ITER;
      ITER: if (cnt_q == '0)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    tag_a_d = tag_a_q;
    tag_b_d = tag_b_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef FIBL_MEMO_EN
    memo_valid_d = memo_valid_q;
    memo_n_d     = memo_n_q;
    n_d          = n_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (memo_hit_c) begin
            // out/ovf already hold the cached result
            done_d = 1'b1;
          end else begin
            a_d     = '0;
            b_d     = intN'(1);
            cnt_d   = bus.in;
            tag_a_d = 1'b0;
            tag_b_d = 1'b0;
`ifdef FIBL_MEMO_EN
            n_d     = bus.in;
`endif
          end
        end
      end
      ITER: begin
        if (cnt_q != '0) begin
          a_d     = b_q;
          b_d     = sum_c[intN-1:0];
          cnt_d   = cnt_q - intN'(1);
          // b runs a term ahead; its overflow only matters once shifted into a
          tag_a_d = tag_b_q;
          tag_b_d = sum_c[intN] | tag_a_q | tag_b_q;
        end else begin
          out_d  = a_q;
          ovf_d  = tag_a_q;
          done_d = 1'b1;
`ifdef FIBL_MEMO_EN
          memo_valid_d = 1'b1;
          memo_n_d     = n_q;
`endif
        end
      end
      default: ;
    endcase
    busy_d = (state_d == ITER);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      tag_a_q <= 1'b0;
      tag_b_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      tag_a_q <= tag_a_d;
      tag_b_q <= tag_b_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FIBL_MEMO_EN
  // Cache registers; an abandoned call never reaches the update above
  always_ff @(posedge clk) begin
    if (rst) begin
      memo_valid_q <= 1'b0;
      memo_n_q     <= '0;
      n_q          <= '0;
    end else begin
      memo_valid_q <= memo_valid_d;
      memo_n_q     <= memo_n_d;
      n_q          <= n_d;
    end
  end
`endif

  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fibl_responder.sv
// Scoreboard bench for fibl_responder: calls push expected results,
// an independent monitor checks every done strobe.
module tb_fibl_responder;

  localparam int unsigned intN = 16;

  typedef struct {
    logic [intN-1:0] out;
    logic            ovf;
    int              busy_cycles;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb[$];

  fibl_responder_if #(.intN(intN)) bus ();

  fibl_responder #(.intN(intN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: counts busy cycles per call and checks each completion
  initial begin : monitor
    int   busy_cnt;
    logic prev_done;
    exp_t e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        check("done_not_busy", 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out", 32'(bus.out), 32'(e.out));
          check("ovf", 32'(bus.ovf), 32'(e.ovf));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
        end
        busy_cnt = 0;
      end else if (bus.busy === 1'b1) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
      prev_done = bus.done;
    end
  end

  // Wait (from a negedge) for done, bounded
  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus.done !== 1'b1) check("done_timeout", 32'd1, 32'd0);
  endtask

  // Issue a call from a negedge and return at the done negedge
  task automatic call(input int n, input int exp_out, input logic exp_ovf,
                      input int exp_busy);
    exp_t e;
    e.out         = intN'(exp_out);
    e.ovf         = exp_ovf;
    e.busy_cycles = exp_busy;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.in    = intN'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.in    = '0;
    wait_done(n + 8);
  endtask

  initial begin : stim
    logic saw_done;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_out",  32'(bus.out),  32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_ovf",  32'(bus.ovf),  32'd0);

    call(0, 0, 1'b0, 1);
    @(negedge clk);
    call(10, 55, 1'b0, 11);
    @(negedge clk);
    call(24, 46368, 1'b0, 25);
    call(25, 9489, 1'b1, 26);
    call(3, 2, 1'b0, 4);
    @(negedge clk);

    // n=20 with stray start pulses while busy; out must hold meanwhile
    sb.push_back('{out: intN'(6765), ovf: 1'b0, busy_cycles: 21});
    bus.start = 1'b1;
    bus.in    = intN'(20);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.start = i[0];
      bus.in    = intN'(7 + i);
      @(negedge clk);
      check("out_hold_while_busy", 32'(bus.out), 32'd2);
    end
    bus.start = 1'b0;
    bus.in    = '0;
    wait_done(30);
    // back-to-back: start presented in the done cycle
    call(5, 5, 1'b0, 6);
    @(negedge clk);

    // Reset mid-call at T0+8; the call is abandoned with no done
    bus.start = 1'b1;
    bus.in    = intN'(20);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_out",  32'(bus.out),  32'd0);
    check("abort_ovf",  32'(bus.ovf),  32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    // Repeat-call behaviour, with and without the cache
    call(12, 144, 1'b0, 13);
    @(negedge clk);
`ifdef FIBL_MEMO_EN
    call(12, 144, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    call(12, 144, 1'b0, 13);
`else
    call(12, 144, 1'b0, 13);
`endif
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
